vga_row_fetch: RTL

VGA_ROW_FETCH -- requirements
Module: vga_row_fetch

---
 rtl/vga_row_fetch_if.sv | 27 ++
 rtl/vga_row_fetch.sv | 119 +++++++++++
 2 files changed

// File: rtl/vga_row_fetch_if.sv
// Row-fetch bus bundle: line request, VGA RAM port, nibble stream and status.
// slave is the fetch block, master is whatever drives requests and the RAM data.
interface vga_row_fetch_if;
  logic         line_start;
  logic [5:0]   line_idx;
  logic [31:0]  read_address;
  logic [159:0] ram_out;
  logic [3:0]   nibble;
  logic [1:0]   field_id;
  logic         nibble_valid;
  logic         nibble_ready;
  logic         busy;
  logic         row_done;
  logic [15:0]  overrun_cnt;

  modport slave (
    input  line_start, line_idx, ram_out, nibble_ready,
    output read_address, nibble, field_id, nibble_valid, busy, row_done,
           overrun_cnt
  );

  modport master (
    output line_start, line_idx, ram_out, nibble_ready,
    input  read_address, nibble, field_id, nibble_valid, busy, row_done,
           overrun_cnt
  );
endinterface

// File: rtl/vga_row_fetch.sv
// VGA row fetch: reads one 160-bit row {instr, reg, data} from the VGA RAM and
// streams it out as 40 hex nibbles, MSB first, with a valid/ready handshake.
// Optional feature macro: VGA_ROW_FETCH_OVERRUN_CNT_EN builds the saturating
// counter of rejected line_start requests; without it overrun_cnt is tied to 0.
//
// state | meaning
// IDLE  | waiting for line_start
// ADDR  | read_address presented, RAM data captured at the end of this cycle
// SHIFT | nibble_valid high, one nibble per accepted transfer
// DONE  | row_done pulse, then back to IDLE
module vga_row_fetch #(
  parameter int ROWS     = 46,
  parameter int REG_ROWS = 32,
  parameter int NIBBLES  = 40
) (
  input logic          clk,
  input logic          rst_n,
  vga_row_fetch_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ADDR, SHIFT, DONE} state_t;

  localparam logic [6:0]   ROWS_W     = 7'(ROWS);
  localparam logic [6:0]   REG_ROWS_W = 7'(REG_ROWS);
  localparam logic [5:0]   LAST_K     = 6'(NIBBLES - 1);
  // Clears the reg field (bits 95:64) for rows that have no register value.
  localparam logic [159:0] REG_KEEP   = ~(160'hFFFF_FFFF << 64);

  state_t       state, state_nxt;
  logic [159:0] shift_q;
  logic [5:0]   k_q;
  logic         oor_q;
  logic         regm_q;
  logic         accept;
  logic         xfer;
  logic         last_xfer;

  assign accept    = (state == IDLE) && bus.line_start;
  assign xfer      = (state == SHIFT) && bus.nibble_ready;
  assign last_xfer = xfer && (k_q == LAST_K);

  // Status outputs decode straight from the state register, so valid never
  // sees nibble_ready combinationally.
  assign bus.busy         = (state == ADDR) || (state == SHIFT);
  assign bus.nibble_valid = (state == SHIFT);
  assign bus.row_done     = (state == DONE);
  assign bus.nibble       = shift_q[159:156];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.line_start) state_nxt = ADDR;
      ADDR:    state_nxt = SHIFT;
      SHIFT:   if (last_xfer) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Field of the current nibble follows the fixed 64/32/64-bit row layout.
  always_comb begin
    bus.field_id = 2'd2;
    if (k_q < 6'd16)      bus.field_id = 2'd0;
    else if (k_q < 6'd24) bus.field_id = 2'd1;
  end

  // Address capture, row latch with masking, and the nibble shifter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.read_address <= '0;
      shift_q          <= '0;
      k_q              <= '0;
      oor_q            <= 1'b0;
      regm_q           <= 1'b0;
    end else begin
      if (accept) begin
        oor_q  <= ({1'b0, bus.line_idx} >= ROWS_W);
        regm_q <= ({1'b0, bus.line_idx} >= REG_ROWS_W);
        k_q    <= '0;
        // Out-of-range rows keep the previous address; their data is zeroed.
        if ({1'b0, bus.line_idx} < ROWS_W)
          bus.read_address <= {26'd0, bus.line_idx};
      end
      if (state == ADDR) begin
        if (oor_q)       shift_q <= '0;
        else if (regm_q) shift_q <= bus.ram_out & REG_KEEP;
        else             shift_q <= bus.ram_out;
      end
      if (xfer && !last_xfer) begin
        shift_q <= {shift_q[155:0], 4'h0};
        k_q     <= k_q + 6'd1;
      end
    end
  end

`ifdef VGA_ROW_FETCH_OVERRUN_CNT_EN
  logic        reject;
  logic [15:0] ovr_q;

  assign reject          = (state != IDLE) && bus.line_start;
  assign bus.overrun_cnt = ovr_q;

  // Saturating count of line_start requests that arrive while a row is active.
  always_ff @(posedge clk) begin
    if (!rst_n)                           ovr_q <= '0;
    else if (reject && ovr_q != 16'hFFFF) ovr_q <= ovr_q + 16'd1;
  end
`else
  assign bus.overrun_cnt = 16'd0;
`endif

endmodule
